// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU run-control slice.
//   CPU_PHASES    : number of phases in one instruction (one-hot width)
//   LAST_PHASE    : index of the phase that ends an instruction
//   run_state_e   : run-control states (HALTED, RUN, STEP, DRAIN, FAULT)
//   onehot_to_idx : binary index of a one-hot vector (up to 8 bits wide)
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int CPU_PHASES = 7;
  localparam int LAST_PHASE = CPU_PHASES - 1;

  typedef enum logic [2:0] {
    HALTED = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    FAULT  = 3'd4
  } run_state_e;

  // OR-ing the indices of all set bits gives the exact index for a true
  // one-hot input, which is the only case the caller relies on.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) begin
        idx = idx | 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cpu_run_control_phase_checker.sv
// ---------------------------------------------------------------------------
// phase_checker
// Sequence-integrity checker for the phase-clock interface. A cycle is
// checked when alive was high the previous cycle; in a checked cycle the
// incoming phase vector must equal the one-hot of the expected phase.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   alive          : enable currently driven to the sequencer
//   clk_sequence   : one-hot phase vector from the sequencer
//   match          : checked cycle and phase vector is the expected one
//   mismatch       : checked cycle and phase vector is wrong
//   last_phase     : checked cycle whose expected phase is the final one
//   phase_idx      : registered index of the last matching phase, else 0
// ---------------------------------------------------------------------------
module phase_checker
  import cpu_pkg::*;
#(
  parameter int PHASES = CPU_PHASES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alive,
  input  logic [PHASES-1:0] clk_sequence,
  output logic              match,
  output logic              mismatch,
  output logic              last_phase,
  output logic [2:0]        phase_idx
);

  localparam logic [2:0]        LAST_IDX     = 3'(PHASES - 1);
  localparam logic [PHASES-1:0] FIRST_ONEHOT = {{(PHASES-1){1'b0}}, 1'b1};

  // alive_d_q is alive delayed by one cycle: the sequencer needs one clock
  // to react to alive, so that is when its output becomes meaningful.
  logic              alive_d_q, alive_d_d;
  logic [2:0]        expected_q, expected_d;
  logic [2:0]        phase_idx_q, phase_idx_d;
  logic [PHASES-1:0] expected_onehot;

  // Compare the phase vector against the expected slot and work out where
  // the expectation moves next. Outside checked cycles the expectation is
  // parked at phase 0 so the first checked cycle always demands phase 0.
  // A mismatch leaves the expectation where it is; the controller faults.
  always_comb begin
    expected_onehot = FIRST_ONEHOT << expected_q;
    alive_d_d       = alive;
    match           = alive_d_q && (clk_sequence == expected_onehot);
    mismatch        = alive_d_q && (clk_sequence != expected_onehot);
    last_phase      = alive_d_q && (expected_q == LAST_IDX);
    expected_d      = expected_q;
    phase_idx_d     = 3'd0;
    if (!alive_d_q) begin
      expected_d = 3'd0;
    end else if (match) begin
      expected_d = (expected_q == LAST_IDX) ? 3'd0 : expected_q + 3'd1;
    end
    if (match) begin
      phase_idx_d = onehot_to_idx(8'(clk_sequence));
    end
  end

  // State registers for the checker.
  always_ff @(posedge clk) begin
    if (rst) begin
      alive_d_q   <= 1'b0;
      expected_q  <= 3'd0;
      phase_idx_q <= 3'd0;
    end else begin
      alive_d_q   <= alive_d_d;
      expected_q  <= expected_d;
      phase_idx_q <= phase_idx_d;
    end
  end

  assign phase_idx = phase_idx_q;

endmodule

// File: rtl/cpu_run_control.sv
// ---------------------------------------------------------------------------
// cpu_run_control
// Controller end of the CPU phase-clock interface: drives alive into the
// one-hot phase sequencer, runs/halts/single-steps on instruction
// boundaries, counts retired instructions and faults on a broken sequence.
// Optional breakpoint: define CPU_RUN_BKPT_EN to add bkpt_en, bkpt_count
// and bkpt_hit.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   clk_sequence  : one-hot phase vector from the sequencer
//   alive         : registered enable to the sequencer
//   run_req       : pulse, start free-running (HALTED only)
//   halt_req      : pulse, stop at next instruction boundary (RUN only)
//   step_req      : pulse, execute one instruction (HALTED only)
//   err_clr       : pulse, leave FAULT for HALTED
//   bkpt_en       : (optional) enable auto-halt on instruction count
//   bkpt_count    : (optional) count at whose boundary RUN halts
//   bkpt_hit      : (optional) sticky, breakpoint caused the last halt
//   running       : RUN, STEP or DRAIN
//   halted        : HALTED
//   phase_idx     : index of the last matching checked phase, else 0
//   instr_done    : one-cycle pulse per completed instruction
//   instr_count   : retired instructions, wraps
//   seq_error     : integrity fault flag, held while in FAULT
// ---------------------------------------------------------------------------
module cpu_run_control
  import cpu_pkg::*;
#(
  parameter int PHASES   = CPU_PHASES,
  parameter int ICOUNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PHASES-1:0]   clk_sequence,
  output logic                alive,
  input  logic                run_req,
  input  logic                halt_req,
  input  logic                step_req,
  input  logic                err_clr,
`ifdef CPU_RUN_BKPT_EN
  input  logic                bkpt_en,
  input  logic [ICOUNT_W-1:0] bkpt_count,
  output logic                bkpt_hit,
`endif
  output logic                running,
  output logic                halted,
  output logic [2:0]          phase_idx,
  output logic                instr_done,
  output logic [ICOUNT_W-1:0] instr_count,
  output logic                seq_error
);

  run_state_e          state_q, state_d;
  logic                alive_q, alive_d;
  logic                instr_done_q, instr_done_d;
  logic [ICOUNT_W-1:0] instr_count_q, instr_count_d;
  logic                seq_error_q, seq_error_d;
  logic                match, mismatch, last_phase;
  logic                boundary;
  logic                bkpt_stop;
`ifdef CPU_RUN_BKPT_EN
  logic                bkpt_hit_q, bkpt_hit_d;
`endif

  phase_checker #(
    .PHASES(PHASES)
  ) u_checker (
    .clk          (clk),
    .rst          (rst),
    .alive        (alive_q),
    .clk_sequence (clk_sequence),
    .match        (match),
    .mismatch     (mismatch),
    .last_phase   (last_phase),
    .phase_idx    (phase_idx)
  );

  // An instruction retires when its final phase arrives in the right order.
  assign boundary = match && last_phase;

  // Run-control next state. Priority inside each state is
  // mismatch > halt > step > run. alive simply follows whether the next
  // state wants the sequencer clocking.
  always_comb begin
`ifdef CPU_RUN_BKPT_EN
    bkpt_stop = bkpt_en && boundary &&
                ((instr_count_q + ICOUNT_W'(1)) == bkpt_count);
`else
    bkpt_stop = 1'b0;
`endif
    state_d = state_q;
    case (state_q)
      HALTED: begin
        if (mismatch) begin
          state_d = FAULT;
        end else if (step_req) begin
          state_d = STEP;
        end else if (run_req) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (mismatch) begin
          state_d = FAULT;
        end else if (boundary && (halt_req || bkpt_stop)) begin
          state_d = HALTED;
        end else if (halt_req) begin
          state_d = DRAIN;
        end
      end
      STEP, DRAIN: begin
        if (mismatch) begin
          state_d = FAULT;
        end else if (boundary) begin
          state_d = HALTED;
        end
      end
      FAULT: begin
        if (err_clr) begin
          state_d = HALTED;
        end
      end
      default: state_d = HALTED;
    endcase
    alive_d       = (state_d == RUN) || (state_d == STEP) || (state_d == DRAIN);
    seq_error_d   = (state_d == FAULT);
    instr_done_d  = boundary;
    instr_count_d = instr_count_q + ICOUNT_W'(boundary);
  end

`ifdef CPU_RUN_BKPT_EN
  // Breakpoint flag: set when the breakpoint ends a RUN, dropped when the
  // user next asks the core to go again.
  always_comb begin
    bkpt_hit_d = bkpt_hit_q;
    if ((state_q == RUN) && bkpt_stop) begin
      bkpt_hit_d = 1'b1;
    end else if (run_req || step_req) begin
      bkpt_hit_d = 1'b0;
    end
  end

  // Breakpoint flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bkpt_hit_q <= 1'b0;
    end else begin
      bkpt_hit_q <= bkpt_hit_d;
    end
  end

  assign bkpt_hit = bkpt_hit_q;
`endif

  // Run-control state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HALTED;
      alive_q       <= 1'b0;
      instr_done_q  <= 1'b0;
      instr_count_q <= '0;
      seq_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      alive_q       <= alive_d;
      instr_done_q  <= instr_done_d;
      instr_count_q <= instr_count_d;
      seq_error_q   <= seq_error_d;
    end
  end

  assign alive       = alive_q;
  assign running     = (state_q == RUN) || (state_q == STEP) || (state_q == DRAIN);
  assign halted      = (state_q == HALTED);
  assign instr_done  = instr_done_q;
  assign instr_count = instr_count_q;
  assign seq_error   = seq_error_q;

endmodule

// File: tb/tb_cpu_run_control.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_control
// Bench for cpu_run_control with a model phase sequencer and a behavioural
// reference of the controller. Define CPU_RUN_BKPT_EN to exercise the
// breakpoint option as well.
// ---------------------------------------------------------------------------
module tb_cpu_run_control;

  localparam int PH = 7;

  localparam int M_HALTED = 0;
  localparam int M_RUN    = 1;
  localparam int M_STEP   = 2;
  localparam int M_DRAIN  = 3;
  localparam int M_FAULT  = 4;

  logic        clk = 1'b0;
  logic        rst, run_req, halt_req, step_req, err_clr;
  logic [6:0]  clk_sequence;
  logic        alive, running, halted, instr_done, seq_error;
  logic [2:0]  phase_idx;
  logic [31:0] instr_count;
  bit          tb_bkpt_en  = 1'b0;
  logic [31:0] tb_bkpt_cnt = '0;
`ifdef CPU_RUN_BKPT_EN
  logic        bkpt_hit;
`endif

  int total = 0;
  int bad   = 0;

  // Model sequencer plus an override used to inject broken phase vectors.
  logic [6:0] seq_q = '0;
  logic       f_en  = 1'b0;
  logic [6:0] f_val = '0;
  assign clk_sequence = f_en ? f_val : seq_q;

  always #5 clk = ~clk;

  // The sequencer advances one phase per clock while alive, wrapping from
  // the last phase to the first, and idles at zero otherwise.
  always @(posedge clk) begin
    if (alive === 1'b1) begin
      seq_q <= (seq_q == 7'd0 || seq_q[6]) ? 7'd1 : (seq_q << 1);
    end else begin
      seq_q <= 7'd0;
    end
  end

  cpu_run_control dut (
    .clk          (clk),
    .rst          (rst),
    .clk_sequence (clk_sequence),
    .alive        (alive),
    .run_req      (run_req),
    .halt_req     (halt_req),
    .step_req     (step_req),
    .err_clr      (err_clr),
`ifdef CPU_RUN_BKPT_EN
    .bkpt_en      (tb_bkpt_en),
    .bkpt_count   (tb_bkpt_cnt),
    .bkpt_hit     (bkpt_hit),
`endif
    .running      (running),
    .halted       (halted),
    .phase_idx    (phase_idx),
    .instr_done   (instr_done),
    .instr_count  (instr_count),
    .seq_error    (seq_error)
  );

  // Reference model: what the outputs should read after the next edge.
  int          m_mode    = M_HALTED;
  bit          m_alive   = 1'b0;
  bit          m_alive_d = 1'b0;
  int          m_pos     = 0;
  bit          m_done    = 1'b0;
  logic [31:0] m_count   = '0;
  logic [2:0]  m_idx     = '0;
  bit          m_err     = 1'b0;
  bit          m_bkpt    = 1'b0;

  task automatic model_step(input bit r, input bit ru, input bit ha, input bit st,
                            input bit cl, input logic [6:0] sq);
    bit chk, mt, mm, bnd, bk;
    int ex, nm;
    if (r) begin
      m_mode = M_HALTED; m_alive = 0; m_alive_d = 0; m_pos = 0; m_done = 0;
      m_count = '0; m_idx = '0; m_err = 0; m_bkpt = 0;
    end else begin
      chk = m_alive_d;
      ex  = m_pos % PH;
      mt  = chk && (sq == (7'd1 << ex));
      mm  = chk && !mt;
      bnd = mt && (ex == PH - 1);
      bk  = tb_bkpt_en && bnd && ((m_count + 32'd1) == tb_bkpt_cnt);
      nm  = m_mode;
      case (m_mode)
        M_HALTED: if (mm) nm = M_FAULT; else if (st) nm = M_STEP; else if (ru) nm = M_RUN;
        M_RUN:    if (mm) nm = M_FAULT; else if (bnd && (ha || bk)) nm = M_HALTED;
                  else if (ha) nm = M_DRAIN;
        M_STEP, M_DRAIN: if (mm) nm = M_FAULT; else if (bnd) nm = M_HALTED;
        default:  if (cl) nm = M_HALTED;
      endcase
      if (m_mode == M_RUN && bk) m_bkpt = 1;
      else if (ru || st) m_bkpt = 0;
      m_pos     = !chk ? 0 : (mt ? m_pos + 1 : m_pos);
      m_idx     = mt ? 3'(ex) : 3'd0;
      m_done    = bnd;
      m_count   = m_count + 32'(bnd);
      m_err     = (nm == M_FAULT);
      m_alive_d = m_alive;
      m_alive   = (nm == M_RUN) || (nm == M_STEP) || (nm == M_DRAIN);
      m_mode    = nm;
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model,
  // and return at the next falling edge with the outputs settled.
  task automatic applyStimulus(input bit r, input bit ru, input bit ha, input bit st,
                               input bit cl, input bit fe, input logic [6:0] fv);
    rst = r; run_req = ru; halt_req = ha; step_req = st; err_clr = cl;
    f_en = fe; f_val = fv;
    model_step(r, ru, ha, st, cl, fe ? fv : seq_q);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input bit ea, input bit eh, input bit er,
                             input logic [2:0] ei, input bit ed, input logic [31:0] ec,
                             input bit ee);
    check_eq({tag, ".alive"},       alive,       ea);
    check_eq({tag, ".halted"},      halted,      eh);
    check_eq({tag, ".running"},     running,     er);
    check_eq({tag, ".phase_idx"},   phase_idx,   ei);
    check_eq({tag, ".instr_done"},  instr_done,  ed);
    check_eq({tag, ".instr_count"}, instr_count, ec);
    check_eq({tag, ".seq_error"},   seq_error,   ee);
  endtask

  task automatic check_model(input string tag);
    checkOutput(tag, m_alive, m_mode == M_HALTED,
                (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN),
                m_idx, m_done, m_count, m_err);
`ifdef CPU_RUN_BKPT_EN
    check_eq({tag, ".bkpt_hit"}, bkpt_hit, m_bkpt);
`endif
  endtask

  task automatic run_cycle(input string tag, input bit ru, input bit ha, input bit st,
                           input bit cl);
    applyStimulus(0, ru, ha, st, cl, 0, 7'd0);
    check_model(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) run_cycle(tag, 0, 0, 0, 0);
  endtask

  task automatic wait_seq(input string tag, input logic [6:0] v);
    for (int i = 0; i < 20 && clk_sequence !== v; i++) run_cycle(tag, 0, 0, 0, 0);
    check_eq({tag, ".reached"}, clk_sequence, v);
  endtask

  // Idle until halted (bounded), counting instr_done pulses and noting
  // alive in the cycle of the last pulse.
  task automatic wait_halted(input string tag, output int nd, output bit al, output int nrun);
    nd = 0; al = 1'b1; nrun = 0;
    for (int i = 0; i < 80; i++) begin
      if (halted === 1'b1) break;
      run_cycle(tag, 0, 0, 0, 0);
      if (running === 1'b1) nrun++;
      if (instr_done === 1'b1) begin
        nd++;
        al = alive;
      end
    end
    check_eq({tag, ".halted"}, halted, 1'b1);
  endtask

  typedef struct {
    bit         rst, run, halt, step, clr;
    bit         alive, halted, running;
    logic [2:0] idx;
    bit         done;
    logic [31:0] count;
    bit         err;
  } vec_t;

  function automatic vec_t mk(bit r, bit ru, bit a, bit h, bit rn, logic [2:0] i,
                              bit d, logic [31:0] c);
    vec_t v;
    v.rst = r; v.run = ru; v.halt = 0; v.step = 0; v.clr = 0;
    v.alive = a; v.halted = h; v.running = rn; v.idx = i; v.done = d;
    v.count = c; v.err = 0;
    return v;
  endfunction

  initial begin
    vec_t vecs[11];
    int   nd, nrun;
    bit   al;
    logic [31:0] c0;
    logic [6:0]  fv;

    // Reset, start running, then watch the first instruction phase by phase.
    vecs[0]  = mk(1, 0, 0, 1, 0, 3'd0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 0, 1, 3'd0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 0, 1, 3'd0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 0, 1, 3'd0, 0, 0);
    vecs[4]  = mk(0, 0, 1, 0, 1, 3'd1, 0, 0);
    vecs[5]  = mk(0, 0, 1, 0, 1, 3'd2, 0, 0);
    vecs[6]  = mk(0, 0, 1, 0, 1, 3'd3, 0, 0);
    vecs[7]  = mk(0, 0, 1, 0, 1, 3'd4, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 1, 3'd5, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 1, 3'd6, 1, 1);
    vecs[10] = mk(0, 0, 1, 0, 1, 3'd0, 0, 1);

    rst = 1; run_req = 0; halt_req = 0; step_req = 0; err_clr = 0;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      if (i == 3) check_eq("first_checked_phase", clk_sequence, 7'b0000001);
      applyStimulus(vecs[i].rst, vecs[i].run, vecs[i].halt, vecs[i].step, vecs[i].clr,
                    0, 7'd0);
      checkOutput($sformatf("vec%0d", i), vecs[i].alive, vecs[i].halted, vecs[i].running,
                  vecs[i].idx, vecs[i].done, vecs[i].count, vecs[i].err);
    end

    // Free-run until three instructions have retired.
    for (int i = 0; i < 30 && instr_count !== 32'd3; i++) run_cycle("run3", 0, 0, 0, 0);
    check_eq("run3.count", instr_count, 32'd3);

    // Halt requested while phase 3 is checked: one more retirement, alive
    // drops with it, and the wrapped phase 0 in the tail is accepted.
    wait_seq("halt_p3", 7'b0001000);
    run_cycle("halt_p3.req", 0, 1, 0, 0);
    wait_halted("halt_p3", nd, al, nrun);
    check_eq("halt_p3.ndone", nd, 1);
    check_eq("halt_p3.alive_at_done", al, 1'b0);
    check_eq("halt_p3.count", instr_count, 32'd4);
    idle("halt_tail", 3);
    check_eq("halt_tail.seq_error", seq_error, 1'b0);

    // Single step: one instruction, eight cycles of running, back to HALTED.
    c0 = m_count;
    run_cycle("step.req", 0, 0, 1, 0);
    wait_halted("step", nd, al, nrun);
    check_eq("step.ndone", nd, 1);
    check_eq("step.nrun", nrun + 1, 8);
    check_eq("step.count", instr_count, c0 + 32'd1);
    idle("step_tail", 3);

    // run_req with halt_req in HALTED runs; halt_req with step_req in RUN
    // drains to the next boundary.
    run_cycle("runhalt", 1, 1, 0, 0);
    check_eq("runhalt.running", running, 1'b1);
    run_cycle("haltstep", 0, 1, 1, 0);
    check_eq("haltstep.running", running, 1'b1);
    wait_halted("drain", nd, al, nrun);
    check_eq("drain.ndone", nd, 1);
    idle("drain_tail", 3);

    // Wrong phase while phase 1 is expected faults the controller.
    run_cycle("fault.run", 1, 0, 0, 0);
    wait_seq("fault.p1", 7'b0000010);
    applyStimulus(0, 0, 0, 0, 0, 1, 7'b0000100);
    check_model("fault.hit");
    check_eq("fault.seq_error", seq_error, 1'b1);
    check_eq("fault.alive", alive, 1'b0);
    idle("fault.hold", 3);
    run_cycle("fault.clr", 0, 0, 0, 1);
    check_eq("fault.clr.halted", halted, 1'b1);
    check_eq("fault.clr.seq_error", seq_error, 1'b0);
    idle("fault.idle", 2);
    c0 = m_count;
    run_cycle("resume", 1, 0, 0, 0);
    for (int i = 0; i < 20 && instr_done !== 1'b1; i++) run_cycle("resume", 0, 0, 0, 0);
    check_eq("resume.done", instr_done, 1'b1);
    check_eq("resume.count", instr_count, c0 + 32'd1);
    check_eq("resume.seq_error", seq_error, 1'b0);

`ifdef CPU_RUN_BKPT_EN
    // Breakpoint at count 5 halts RUN after the fifth retirement.
    applyStimulus(1, 0, 0, 0, 0, 0, 7'd0);
    check_model("bkpt.rst");
    tb_bkpt_en = 1'b1; tb_bkpt_cnt = 32'd5;
    run_cycle("bkpt.run", 1, 0, 0, 0);
    wait_halted("bkpt", nd, al, nrun);
    check_eq("bkpt.ndone", nd, 5);
    check_eq("bkpt.count", instr_count, 32'd5);
    check_eq("bkpt.hit", bkpt_hit, 1'b1);
    idle("bkpt.tail", 3);
    run_cycle("bkpt.step", 0, 0, 1, 0);
    check_eq("bkpt.cleared", bkpt_hit, 1'b0);
    wait_halted("bkpt.stepdone", nd, al, nrun);
    tb_bkpt_en = 1'b0;
`endif

    // Random requests, occasional corrupted phases and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      fv = ($urandom_range(0, 1) == 1) ? (7'd1 << $urandom_range(0, 6)) : 7'($urandom);
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0, fv);
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
